// File: rtl/async_fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one async FIFO write port among NUM_REQ requesters.
// FIFO words are {last, id, data}; a grant lasts until the last beat or the beat limit.
module async_fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ID_WIDTH      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned FIFO_WIDTH    = DATA_WIDTH + ID_WIDTH + 1,
    parameter int unsigned MAX_PKT_BEATS = 16
) (
    input  logic                             fifo_wclk,
    input  logic                             fifo_wrst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             fifo_full,
    output logic                             fifo_wen,
    output logic [FIFO_WIDTH-1:0]            fifo_wdata,
    output logic                             arb_busy,
    output logic [ID_WIDTH-1:0]              arb_grant_id,
    output logic [15:0]                      arb_pkt_count,
    output logic                             arb_trunc_pulse
);

    localparam int unsigned BeatW = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [BeatW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic                  trunc_q, trunc_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [ID_WIDTH-1:0]   sel_id;
    logic [ID_WIDTH-1:0]   cand;
    logic                  force_last;
    logic                  last_bit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from farthest to nearest so the first valid after last_grant wins.
    always_comb begin
        sel_id = '0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_WIDTH'((32'(last_grant_q) + 32'(k)) % NUM_REQ);
            if (req_valid[cand]) begin
                sel_id = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_count_d  = pkt_count_q;
        trunc_d      = 1'b0;
        req_ready    = '0;
        fifo_wen     = 1'b0;
        fifo_wdata   = '0;
        force_last   = (beat_cnt_q == BeatW'(MAX_PKT_BEATS - 1));
        last_bit     = req_last[grant_q] | force_last;

        unique case (state_q)
            StIdle: begin
                beat_cnt_d = '0;
                if (|req_valid) begin
                    grant_d = sel_id;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                req_ready[grant_q] = ~fifo_full;
                if (req_valid[grant_q] && !fifo_full) begin
                    fifo_wen   = 1'b1;
                    fifo_wdata = {last_bit, grant_q, data_arr[grant_q]};
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_bit) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                        pkt_count_d  = pkt_count_q + 16'd1;
                        trunc_d      = force_last & ~req_last[grant_q];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset points last_grant at the top requester so requester 0 wins first.
    always_ff @(posedge fifo_wclk or posedge fifo_wrst) begin
        if (fifo_wrst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            pkt_count_q  <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_count_q  <= pkt_count_d;
            trunc_q      <= trunc_d;
        end
    end

    assign arb_busy        = (state_q == StXfer);
    assign arb_grant_id    = grant_q;
    assign arb_pkt_count   = pkt_count_q;
    assign arb_trunc_pulse = trunc_q;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: per-requester beat queues drive the DUT and
// every FIFO write is logged, then compared against hand-computed words and cycles.
module tb_async_fifo_wr_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int IW  = 2;
    localparam int FW  = 11;
    localparam int MPB = 16;

    logic              fifo_wclk = 1'b0;
    logic              fifo_wrst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wen;
    logic [FW-1:0]     fifo_wdata;
    logic              arb_busy;
    logic [IW-1:0]     arb_grant_id;
    logic [15:0]       arb_pkt_count;
    logic              arb_trunc_pulse;

    async_fifo_wr_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .ID_WIDTH     (IW),
        .FIFO_WIDTH   (FW),
        .MAX_PKT_BEATS(MPB)
    ) dut (
        .fifo_wclk      (fifo_wclk),
        .fifo_wrst      (fifo_wrst),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_wen       (fifo_wen),
        .fifo_wdata     (fifo_wdata),
        .arb_busy       (arb_busy),
        .arb_grant_id   (arb_grant_id),
        .arb_pkt_count  (arb_pkt_count),
        .arb_trunc_pulse(arb_trunc_pulse)
    );

    always #5 fifo_wclk = ~fifo_wclk;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            st;
    int            bad;
    logic [8:0]    q [NR][$];  // {last, data}
    logic [NR-1:0] hold;
    logic [FW-1:0] wlog [$];
    int            wcyc [$];
    int            tcyc [$];
    logic [NR-1:0] s_ready;
    logic          s_wen;
    logic          s_busy;
    logic [IW-1:0] s_gid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wat(input int k);
        return (k < wlog.size()) ? 32'(wlog[k]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] cat(input int k);
        return (k < wcyc.size()) ? 32'(wcyc[k]) : 32'hFFFF_FFFF;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"},   32'(fifo_wen),        32'd0);
        check({tag, "_ready"}, 32'(req_ready),       32'd0);
        check({tag, "_busy"},  32'(arb_busy),        32'd0);
        check({tag, "_gid"},   32'(arb_grant_id),    32'd0);
        check({tag, "_pkt"},   32'(arb_pkt_count),   32'd0);
        check({tag, "_trunc"}, 32'(arb_trunc_pulse), 32'd0);
        check({tag, "_wdata"}, 32'(fifo_wdata),      32'd0);
    endtask

    // Called at posedge+1: drive, sample mid-cycle, pop accepted beats at the next edge.
    task automatic step();
        logic [NR-1:0] acc;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (q[i].size() != 0) && !hold[i];
            req_last[i]  = req_valid[i] ? q[i][0][8] : 1'b0;
            req_data[i*DW +: DW] = req_valid[i] ? q[i][0][7:0] : 8'h00;
        end
        #3;
        s_ready = req_ready;
        s_wen   = fifo_wen;
        s_busy  = arb_busy;
        s_gid   = arb_grant_id;
        if (fifo_wen) begin
            wlog.push_back(fifo_wdata);
            wcyc.push_back(cyc);
        end
        if (arb_trunc_pulse) tcyc.push_back(cyc);
        acc = req_ready & req_valid;
        @(posedge fifo_wclk);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) void'(q[i].pop_front());
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        fifo_wrst = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        hold      = '0;
        for (int i = 0; i < NR; i++) q[i].delete();
        wlog.delete();
        wcyc.delete();
        tcyc.delete();
        repeat (2) @(posedge fifo_wclk);
        #1;
        fifo_wrst = 1'b0;
    endtask

    initial begin
        // Reset values
        fifo_wrst = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        hold      = '0;
        repeat (2) @(posedge fifo_wclk);
        #1;
        check_reset_outputs("rst");
        fifo_wrst = 1'b0;
        step();
        check("idle_no_wen", 32'(s_wen), 32'd0);

        // Requester 2: three beats, last on the third
        do_reset();
        q[2].push_back({1'b0, 8'hA1});
        q[2].push_back({1'b0, 8'hA2});
        q[2].push_back({1'b1, 8'hA3});
        st = cyc;
        step();
        check("s1_idle_ready", 32'(s_ready), 32'd0);
        repeat (6) step();
        check("s1_nwrites", 32'(wlog.size()), 32'd3);
        check("s1_w0", wat(0), 32'h2A1);
        check("s1_w1", wat(1), 32'h2A2);
        check("s1_w2", wat(2), 32'h6A3);
        check("s1_c0", cat(0), 32'(st + 1));
        check("s1_c2", cat(2), 32'(st + 3));
        check("s1_pkt", 32'(arb_pkt_count), 32'd1);
        check("s1_gid", 32'(arb_grant_id), 32'd2);
        check("s1_busy", 32'(arb_busy), 32'd0);

        // All four requesters, two 1-beat packets each
        do_reset();
        for (int i = 0; i < NR; i++) begin
            q[i].push_back({1'b1, 8'(8'hB0 + i)});
            q[i].push_back({1'b1, 8'(8'hC0 + i)});
        end
        repeat (20) step();
        check("s2_w0", wat(0), 32'h4B0);
        check("s2_w1", wat(1), 32'h5B1);
        check("s2_w2", wat(2), 32'h6B2);
        check("s2_w3", wat(3), 32'h7B3);
        check("s2_w4", wat(4), 32'h4C0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s2_gap%0d", k), cat(k + 1) - cat(k), 32'd2);
        end
        check("s2_pkt", 32'(arb_pkt_count), 32'd8);

        // Requester 1 with fifo_full for 5 cycles mid-packet
        do_reset();
        for (int b = 1; b <= 5; b++) q[1].push_back({(b == 5), 8'(8'hD0 + b)});
        st  = cyc;
        bad = 0;
        for (int s = 0; s < 13; s++) begin
            fifo_full = (s >= 3 && s <= 7);
            step();
            if (s >= 3 && s <= 7) begin
                if (s_wen || (s_ready != '0) || !s_busy) bad++;
            end
        end
        fifo_full = 1'b0;
        check("s3_stall", 32'(bad), 32'd0);
        check("s3_nwrites", 32'(wlog.size()), 32'd5);
        check("s3_w1", wat(1), 32'h1D2);
        check("s3_w2", wat(2), 32'h1D3);
        check("s3_w4", wat(4), 32'h5D5);
        check("s3_c1", cat(1), 32'(st + 2));
        check("s3_c2", cat(2), 32'(st + 8));
        check("s3_pkt", 32'(arb_pkt_count), 32'd1);

        // Requester 0: 20 beats, truncated at 16
        do_reset();
        for (int b = 1; b <= 20; b++) q[0].push_back({(b == 20), 8'(b)});
        repeat (26) step();
        check("s4_nwrites", 32'(wlog.size()), 32'd20);
        check("s4_w14", wat(14), 32'h00F);
        check("s4_w15", wat(15), 32'h410);
        check("s4_w16", wat(16), 32'h011);
        check("s4_w19", wat(19), 32'h414);
        check("s4_bubble", cat(16) - cat(15), 32'd2);
        check("s4_ntrunc", 32'(tcyc.size()), 32'd1);
        check("s4_tcyc", (tcyc.size() > 0) ? 32'(tcyc[0]) : 32'hFFFF_FFFF, cat(15) + 1);
        check("s4_pkt", 32'(arb_pkt_count), 32'd2);

        // Requester 3 pauses mid-packet while requester 0 waits
        do_reset();
        q[3].push_back({1'b0, 8'hE1});
        q[3].push_back({1'b0, 8'hE2});
        q[3].push_back({1'b1, 8'hE3});
        st  = cyc;
        bad = 0;
        for (int s = 0; s < 12; s++) begin
            if (s == 2) q[0].push_back({1'b1, 8'hF0});
            hold[3] = (s >= 3 && s <= 5);
            step();
            if (s >= 3 && s <= 5 && (s_wen || s_gid != 2'd3)) bad++;
            if (s >= 2 && s <= 6 && s_ready[0]) bad++;
        end
        hold = '0;
        check("s5_hold", 32'(bad), 32'd0);
        check("s5_w1", wat(1), 32'h3E2);
        check("s5_w2", wat(2), 32'h7E3);
        check("s5_w3", wat(3), 32'h4F0);
        check("s5_c2", cat(2), 32'(st + 6));
        check("s5_c3", cat(3), 32'(st + 8));

        // Reset pulsed during a transfer
        do_reset();
        q[2].push_back({1'b0, 8'h91});
        q[2].push_back({1'b0, 8'h92});
        q[2].push_back({1'b0, 8'h93});
        q[2].push_back({1'b1, 8'h94});
        repeat (3) step();
        check("s6_pre_busy", 32'(arb_busy), 32'd1);
        fifo_wrst = 1'b1;
        #2;
        check_reset_outputs("s6_rst");
        @(posedge fifo_wclk);
        #1;
        fifo_wrst = 1'b0;
        wlog.delete();
        wcyc.delete();
        q[1].push_back({1'b1, 8'h55});
        step();
        step();
        check("s6_gid", 32'(s_gid), 32'd1);
        repeat (6) step();
        check("s6_w0", wat(0), 32'h555);
        check("s6_w1", wat(1), 32'h293);
        check("s6_w2", wat(2), 32'h694);
        check("s6_pkt", 32'(arb_pkt_count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
